// File: rtl/npc_pc_unit.sv
// Fetch program counter with next-PC selection: sequential, branch, jump,
// register jump, eret and exception redirect, plus F-stage delay-slot/AdEL flags.
module npc_pc_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        IntReq,
  input  logic [31:0] EPC,
  input  logic [31:0] D_Instr,
  input  logic [31:0] D_PC,
  input  logic        ifBr,
  input  logic [31:0] RData1,
  output logic [31:0] F_PC,
  output logic        F_BD,
  output logic        F_AdEL,
  output logic        D_BD,
  output logic        ExcEntry
);

  typedef enum logic {ST_RUN = 1'b0, ST_EXC = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        d_bd_q, d_bd_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rt;
  logic        is_b, is_j, is_jr, is_eret;
  logic [31:0] d_pc_plus4, br_target, j_target;

  assign opcode = D_Instr[31:26];
  assign rt     = D_Instr[20:16];
  assign funct  = D_Instr[5:0];

  assign is_b    = (opcode == 6'b000100) || (opcode == 6'b000101) ||
                   (opcode == 6'b000110) || (opcode == 6'b000111) ||
                   ((opcode == 6'b000001) &&
                    ((rt == 5'b00000) || (rt == 5'b00001) || (rt == 5'b10001)));
  assign is_j    = (opcode == 6'b000010) || (opcode == 6'b000011);
  assign is_jr   = (opcode == 6'b000000) && ((funct == 6'b001000) || (funct == 6'b001001));
  assign is_eret = (opcode == 6'b010000) && (funct == 6'b011000);

  assign d_pc_plus4 = D_PC + 32'd4;
  assign br_target  = d_pc_plus4 + {{14{D_Instr[15]}}, D_Instr[15:0], 2'b00};
  assign j_target   = {d_pc_plus4[31:28], D_Instr[25:0], 2'b00};

  // Exception redirect beats a stall; eret waits for the stall to clear
  // because its EPC operand may still be in flight.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (IntReq)                pc_d = EXC_VEC;
    else if (is_eret && !Stall) pc_d = EPC;
    else if (Stall)            pc_d = pc_q;
    else if (is_b && ifBr)     pc_d = br_target;
    else if (is_j)             pc_d = j_target;
    else if (is_jr)            pc_d = RData1;
  end

  always_comb begin
    d_bd_d = d_bd_q;
    if (IntReq)      d_bd_d = 1'b0;
    else if (!Stall) d_bd_d = F_BD;
  end

  always_comb begin
    state_d = ST_RUN;
    if (IntReq) state_d = ST_EXC;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      d_bd_q  <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      d_bd_q  <= d_bd_d;
      state_q <= state_d;
    end
  end

  assign F_PC     = pc_q;
  assign F_BD     = is_b | is_j | is_jr;
  assign F_AdEL   = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
  assign D_BD     = d_bd_q;
  assign ExcEntry = (state_q == ST_EXC);

endmodule

// File: tb/tb_npc_pc_unit.sv
// Directed bench for npc_pc_unit: hand-computed next-PC, delay-slot,
// address-error and exception-entry expectations checked after each edge.
module tb_npc_pc_unit;

  logic        clk = 1'b0;
  logic        reset, Stall, IntReq, ifBr;
  logic [31:0] EPC, D_Instr, D_PC, RData1;
  logic [31:0] F_PC;
  logic        F_BD, F_AdEL, D_BD, ExcEntry;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] BEQ_M4  = 32'h1000_fffc;   // beq $0,$0,-4
  localparam logic [31:0] BNE_P4  = 32'h1400_0004;   // bne $0,$0,+4
  localparam logic [31:0] BGEZAL1 = 32'h0411_0001;   // bgezal $0,+1
  localparam logic [31:0] REGIMM2 = 32'h0402_0001;   // regimm rt=00010: not a branch
  localparam logic [31:0] JR_R5   = 32'h00a0_0008;   // jr $5
  localparam logic [31:0] JAL_IDX = 32'h0c00_0c10;   // jal 0x0c10 -> 0x3040
  localparam logic [31:0] ERET    = 32'h4200_0018;

  npc_pc_unit dut (
    .clk(clk), .reset(reset), .Stall(Stall), .IntReq(IntReq), .EPC(EPC),
    .D_Instr(D_Instr), .D_PC(D_PC), .ifBr(ifBr), .RData1(RData1),
    .F_PC(F_PC), .F_BD(F_BD), .F_AdEL(F_AdEL), .D_BD(D_BD), .ExcEntry(ExcEntry)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; IntReq = 1'b0; ifBr = 1'b0;
    EPC = 32'h0; D_Instr = NOP; D_PC = 32'h0; RData1 = 32'h0;
    tick();
    check("rst_pc", F_PC, 32'h3000);
    check("rst_dbd", {31'b0, D_BD}, 32'd0);
    check("rst_exc", {31'b0, ExcEntry}, 32'd0);
    reset = 1'b0;
    check("idle_fbd", {31'b0, F_BD}, 32'd0);
    check("idle_adel", {31'b0, F_AdEL}, 32'd0);
    tick(); check("idle_pc1", F_PC, 32'h3004);
    tick(); check("idle_pc2", F_PC, 32'h3008);
    tick(); check("idle_pc3", F_PC, 32'h300c);
    check("idle_adel3", {31'b0, F_AdEL}, 32'd0);

    // taken beq: 0x3014 - 16 = 0x3004
    D_PC = 32'h3010; D_Instr = BEQ_M4; ifBr = 1'b1; #1;
    check("beq_fbd", {31'b0, F_BD}, 32'd1);
    tick();
    check("beq_pc", F_PC, 32'h3004);
    check("beq_dbd", {31'b0, D_BD}, 32'd1);
    D_Instr = NOP; ifBr = 1'b0; #1;
    check("nop_fbd", {31'b0, F_BD}, 32'd0);
    tick();
    check("nop_pc", F_PC, 32'h3008);
    check("nop_dbd", {31'b0, D_BD}, 32'd0);
    D_Instr = BEQ_M4; ifBr = 1'b0;
    tick();
    check("beq_nt_pc", F_PC, 32'h300c);
    check("beq_nt_dbd", {31'b0, D_BD}, 32'd1);

    // regimm decode: bgezal taken, rt=00010 sequential
    D_PC = 32'h3000; D_Instr = BGEZAL1; ifBr = 1'b1; #1;
    check("bgezal_fbd", {31'b0, F_BD}, 32'd1);
    tick(); check("bgezal_pc", F_PC, 32'h3008);
    D_Instr = REGIMM2; #1;
    check("regimm2_fbd", {31'b0, F_BD}, 32'd0);
    tick(); check("regimm2_pc", F_PC, 32'h300c);
    ifBr = 1'b0;

    // jr targets, including misaligned and range edges
    D_Instr = JR_R5; RData1 = 32'h3002;
    tick();
    check("jr_pc", F_PC, 32'h3002);
    check("jr_adel_mis", {31'b0, F_AdEL}, 32'd1);
    RData1 = 32'h7000; tick();
    check("jr_adel_hi", {31'b0, F_AdEL}, 32'd1);
    RData1 = 32'h6ffc; tick();
    check("jr_adel_top", {31'b0, F_AdEL}, 32'd0);
    RData1 = 32'h2ffc; tick();
    check("jr_adel_lo", {31'b0, F_AdEL}, 32'd1);

    // jal
    D_PC = 32'h3020; D_Instr = JAL_IDX;
    tick(); check("jal_pc", F_PC, 32'h3040);
    D_Instr = NOP;
    tick(); check("pre_stall_pc", F_PC, 32'h3044);
    check("pre_stall_dbd", {31'b0, D_BD}, 32'd0);

    // stall with taken bne held for two cycles
    D_PC = 32'h3050; D_Instr = BNE_P4; ifBr = 1'b1; Stall = 1'b1;
    tick();
    check("stall1_pc", F_PC, 32'h3044);
    check("stall1_dbd", {31'b0, D_BD}, 32'd0);
    tick();
    check("stall2_pc", F_PC, 32'h3044);
    check("stall2_dbd", {31'b0, D_BD}, 32'd0);
    Stall = 1'b0;
    tick();
    check("unstall_pc", F_PC, 32'h3064);
    check("unstall_dbd", {31'b0, D_BD}, 32'd1);

    // exception while stalled with a taken branch
    Stall = 1'b1; IntReq = 1'b1;
    tick();
    check("exc_pc", F_PC, 32'h4180);
    check("exc_entry", {31'b0, ExcEntry}, 32'd1);
    check("exc_dbd", {31'b0, D_BD}, 32'd0);
    Stall = 1'b0; IntReq = 1'b0; D_Instr = NOP; ifBr = 1'b0;
    tick();
    check("exc_done_pc", F_PC, 32'h4184);
    check("exc_done_entry", {31'b0, ExcEntry}, 32'd0);

    // back-to-back exception requests re-enter EXC
    IntReq = 1'b1; tick();
    tick();
    check("reexc_pc", F_PC, 32'h4180);
    check("reexc_entry", {31'b0, ExcEntry}, 32'd1);
    IntReq = 1'b0; tick();
    check("reexc_exit", {31'b0, ExcEntry}, 32'd0);
    check("reexc_pc2", F_PC, 32'h4184);

    // eret held by stall, then taken; then eret + IntReq
    D_Instr = ERET; EPC = 32'h3040; Stall = 1'b1; #1;
    check("eret_fbd", {31'b0, F_BD}, 32'd0);
    tick(); check("eret_stall_pc", F_PC, 32'h4184);
    Stall = 1'b0;
    tick(); check("eret_pc", F_PC, 32'h3040);
    IntReq = 1'b1;
    tick(); check("eret_int_pc", F_PC, 32'h4180);
    IntReq = 1'b0;

    // PC+4 wrap
    D_Instr = JR_R5; RData1 = 32'hffff_fffc;
    tick(); check("wrap_pre_pc", F_PC, 32'hffff_fffc);
    check("wrap_pre_adel", {31'b0, F_AdEL}, 32'd1);
    D_Instr = NOP;
    tick(); check("wrap_pc", F_PC, 32'h0000_0000);
    check("wrap_adel", {31'b0, F_AdEL}, 32'd1);

    // reset during EXC and stall
    IntReq = 1'b1; tick();
    check("pre_rst_entry", {31'b0, ExcEntry}, 32'd1);
    reset = 1'b1; Stall = 1'b1;
    tick();
    check("midexc_rst_pc", F_PC, 32'h3000);
    check("midexc_rst_entry", {31'b0, ExcEntry}, 32'd0);
    reset = 1'b0; IntReq = 1'b0; Stall = 1'b0;
    tick(); check("post_rst_pc", F_PC, 32'h3004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/npc_pc_unit.md
Name: npc_pc_unit

Overview:
- Fetch-side program-counter register and next-PC selector for the 5-stage MIPS pipeline; the consumer of the ID-stage branch comparator's ifBr decision.
- Each cycle it picks the next fetch address from:
  - sequential PC+4;
  - taken branch target;
  - j/jal target;
  - jr/jalr register target;
  - eret return address (EPC);
  - exception vector.
- It also generates the delay-slot flag and the instruction-fetch address-error flag for F.

Parameters:
PC_RESET, 32'h0000_3000, PC value after reset
EXC_VEC, 32'h0000_4180, exception/interrupt handler entry
IM_LO, 32'h0000_3000, lowest legal fetch address
IM_HI, 32'h0000_6ffc, highest legal fetch address

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
Stall  in  1  hazard stall: hold F and D
IntReq  in  1  CP0 exception/interrupt request: redirect to EXC_VEC
EPC  in  32  CP0 EPC, forwarded value
D_Instr  in  32  instruction in ID
D_PC  in  32  PC of instruction in ID
ifBr  in  1  branch condition result for D_Instr (from comparator)
RData1  in  32  forwarded rs value in ID (jr/jalr target)
F_PC  out  32  current fetch address
F_BD  out  1  instruction in F is a delay slot
F_AdEL  out  1  fetch address error
D_BD  out  1  registered F_BD, aligned with the ID instruction
ExcEntry  out  1  one-cycle pulse: F_PC is the first handler fetch

Behaviour:
- Reset values (reset sampled on clk): F_PC=PC_RESET, D_BD=0, ExcEntry=0, FSM=RUN. reset overrides every other input.
- Decode of D_Instr:
  - Branch (B): opcodes 000100 beq, 000101 bne, 000110 blez, 000111 bgtz; or 000001 with rt 00000 bltz, 00001 bgez, 10001 bgezal.
  - J: j 000010, jal 000011.
  - JR: opcode 000000 with funct 001000 jr / 001001 jalr.
  - ERET: opcode 010000 with funct 011000.
  - CTI = B | J | JR.
  - Any other encoding is sequential.
- Next-PC priority (highest first):
  1. IntReq -> EXC_VEC; applies even when Stall=1.
  2. ERET and !Stall -> EPC (eret has no delay slot).
  3. Stall -> hold F_PC.
  4. B & ifBr -> D_PC + 4 + (sext(D_Instr[15:0]) << 2), modulo 2^32.
  5. J -> {D_PC[31:28] + carry-free upper bits of D_PC+4, D_Instr[25:0], 2'b00}, i.e. {(D_PC+4)[31:28], idx, 00}.
  6. JR -> RData1, unmodified; misalignment is reported through F_AdEL, not corrected.
  7. Otherwise -> F_PC + 4.
- Branch not taken (B & !ifBr) -> F_PC+4.
- F_BD = CTI(D_Instr), combinational.
- D_BD:
  - !Stall: D_BD <= F_BD.
  - Stall: hold.
  - IntReq: D_BD <= 0.
- F_AdEL (combinational) = (F_PC[1:0] != 0) | (F_PC < IM_LO) | (F_PC > IM_HI).
- FSM:
  - RUN -> EXC on IntReq.
  - EXC -> RUN unconditionally after one cycle.
  - ExcEntry = 1 only in EXC.
  - IntReq while in EXC re-enters EXC (F_PC stays EXC_VEC).
- Simultaneous events:
  - IntReq + ERET -> EXC_VEC.
  - IntReq + taken branch -> EXC_VEC.
  - Stall + ERET -> hold (EPC hazard is still unresolved).
- PC+4 wraps at 2^32 without error; the wrapped value raises F_AdEL.
- Reset mid-stall or mid-EXC returns to PC_RESET/RUN on the same edge.

Test Plan:
- Reset, then 3 cycles idle with D_Instr=nop -> F_PC 3000, 3004, 3008, 300c; F_BD=0; F_AdEL=0.
- D_PC=3010, D_Instr=beq imm=16'hfffc, ifBr=1 -> next F_PC=3004, F_BD=1 that cycle, D_BD=1 next cycle. Same with ifBr=0 -> F_PC+4.
- D_Instr=jr, RData1=32'h3002 -> F_PC=3002, F_AdEL=1. RData1=32'h7000 -> F_AdEL=1.
- Stall=1 for 2 cycles with a taken bne in D -> F_PC and D_BD hold. Stall=0 -> F_PC=branch target.
- IntReq=1 with Stall=1 and a taken branch in D -> next F_PC=4180, ExcEntry=1 for exactly one cycle, D_BD=0.
- D_Instr=eret, EPC=32'h3040: Stall=1 -> F_PC holds; Stall=0 -> F_PC=3040, F_BD=0. Repeat with IntReq=1 -> F_PC=4180.
